// File: rtl/seqdivider_if.sv
// Start/busy/done handshake plus operand and result bundle for seqdivider.
// The controller side uses the master modport, the divider uses slave.
interface seqdivider_if #(
    parameter int n = 4
);
    logic         start;
    logic [n-1:0] A;
    logic [n-1:0] B;
    logic         busy;
    logic         done;
    logic [n-1:0] Q;
    logic [n-1:0] R;
    logic         divzero;

    modport master (
        output start, A, B,
        input  busy, done, Q, R, divzero
    );

    modport slave (
        input  start, A, B,
        output busy, done, Q, R, divzero
    );
endinterface

// File: rtl/seqdivider.sv
// Iterative unsigned restoring divider: Q = A / B, R = A mod B, one quotient bit per clock.
// Optional macro SEQDIVIDER_DIVZERO_EN: B=0 short-cuts straight to DONE and raises divzero.
module seqdivider #(
    parameter int n = 4
) (
    input  logic       clk,
    input  logic       n_reset,
    seqdivider_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int CW = $clog2(n);
    localparam logic [CW-1:0] LAST = CW'(n - 1);

    state_t       state_reg;
    logic [CW-1:0] count_reg;
    logic [n-1:0] dividend_reg;
    logic [n-1:0] divisor_reg;
    logic [n-1:0] rem_reg;
    logic [n-1:0] q_reg;
    logic [n-1:0] r_reg;
    logic         busy_reg;
    logic         done_reg;

    logic [n:0]   rem_shift;
    logic [n:0]   trial;
    logic         q_bit;
    logic [n-1:0] rem_next;
    logic [n-1:0] dividend_next;

    // The partial remainder is always below the divisor, so bit n of the
    // (n+1)-bit trial difference is a reliable sign bit.
    always_comb begin
        rem_shift     = {rem_reg, dividend_reg[n-1]};
        trial         = rem_shift - {1'b0, divisor_reg};
        q_bit         = ~trial[n];
        rem_next      = q_bit ? trial[n-1:0] : rem_shift[n-1:0];
        dividend_next = {dividend_reg[n-2:0], q_bit};
    end

`ifdef SEQDIVIDER_DIVZERO_EN
    logic divzero_reg;
    assign bus.divzero = divzero_reg;
`else
    assign bus.divzero = 1'b0;
`endif

    assign bus.busy = busy_reg;
    assign bus.done = done_reg;
    assign bus.Q    = q_reg;
    assign bus.R    = r_reg;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_reg    <= IDLE;
            count_reg    <= '0;
            dividend_reg <= '0;
            divisor_reg  <= '0;
            rem_reg      <= '0;
            q_reg        <= '0;
            r_reg        <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
`ifdef SEQDIVIDER_DIVZERO_EN
            divzero_reg  <= 1'b0;
`endif
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE, DONE: begin
                    if (bus.start) begin
`ifdef SEQDIVIDER_DIVZERO_EN
                        if (bus.B == '0) begin
                            state_reg   <= DONE;
                            done_reg    <= 1'b1;
                            busy_reg    <= 1'b0;
                            q_reg       <= '1;
                            r_reg       <= bus.A;
                            divzero_reg <= 1'b1;
                        end else begin
`else
                        begin
`endif
                            dividend_reg <= bus.A;
                            divisor_reg  <= bus.B;
                            rem_reg      <= '0;
                            count_reg    <= '0;
                            busy_reg     <= 1'b1;
                            state_reg    <= RUN;
                        end
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                RUN: begin
                    dividend_reg <= dividend_next;
                    rem_reg      <= rem_next;
                    count_reg    <= count_reg + 1'b1;
                    if (count_reg == LAST) begin
                        state_reg <= DONE;
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        q_reg     <= dividend_next;
                        r_reg     <= rem_next;
`ifdef SEQDIVIDER_DIVZERO_EN
                        divzero_reg <= 1'b0;
`endif
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seqdivider.sv
// Scoreboard bench for seqdivider (n=4): expected results are queued when an
// operation is issued and popped when done is observed.
module tb_seqdivider;
    localparam int N = 4;
`ifdef SEQDIVIDER_DIVZERO_EN
    localparam bit DZ_EN = 1'b1;
`else
    localparam bit DZ_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic n_reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    seqdivider_if #(.n(N)) bus();

    seqdivider #(.n(N)) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] q;
        logic [3:0] r;
        logic       dz;
        int         lat;
    } exp_t;

    exp_t sb[$];

    // Called right after a falling edge; the next rising edge accepts.
    task automatic issue(input logic [3:0] a, input logic [3:0] b);
        exp_t e;
        e.a = a;
        e.b = b;
        if (b == 4'd0) begin
            e.q   = 4'hF;
            e.r   = a;
            e.dz  = DZ_EN;
            e.lat = DZ_EN ? 1 : N + 1;
        end else begin
            e.q   = a / b;
            e.r   = a % b;
            e.dz  = 1'b0;
            e.lat = N + 1;
        end
        sb.push_back(e);
        bus.start = 1'b1;
        bus.A     = a;
        bus.B     = b;
    endtask

    // Counts falling edges after the accept until done; lat=-1 on timeout.
    task automatic wait_done(input bit hold, input int poke, output int lat, output int busy_cnt);
        bit seen;
        lat = -1;
        busy_cnt = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bus.busy) busy_cnt++;
            seen = bus.done;
            if (!hold) begin
                if (i == poke) begin
                    bus.start = 1'b1;
                    bus.A = 4'd2;
                    bus.B = 4'd2;
                end else begin
                    bus.start = 1'b0;
                end
            end
            if (seen) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.A = '0;
        bus.B = '0;
        n_reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.divzero} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got busy/done/divzero=%b required 000", {bus.busy, bus.done, bus.divzero});
        end
        checks++;
        if ({bus.Q, bus.R} !== 8'h00) begin
            errors++;
            $display("FAIL reset_qr: got Q=%0d R=%0d required 0/0", bus.Q, bus.R);
        end
        n_reset = 1'b1;
    endtask

    task automatic test_basic();
        exp_t e;
        int lat, bc;
        @(negedge clk);
        issue(4'd13, 4'd3);
        wait_done(1'b0, 0, lat, bc);
        e = sb.pop_front();
        $display("txn basic A=%0d B=%0d Q=%0d R=%0d divzero=%0d lat=%0d", e.a, e.b, bus.Q, bus.R, bus.divzero, lat);
        checks++;
        if (lat != e.lat || bc != e.lat - 1) begin
            errors++;
            $display("FAIL basic_latency: got lat=%0d busy=%0d required lat=%0d busy=%0d", lat, bc, e.lat, e.lat - 1);
        end
        checks++;
        if (bus.Q !== e.q || bus.R !== e.r || bus.divzero !== e.dz) begin
            errors++;
            $display("FAIL basic_result: got Q=%0d R=%0d dz=%0d required Q=%0d R=%0d dz=%0d", bus.Q, bus.R, bus.divzero, e.q, e.r, e.dz);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.Q !== e.q || bus.R !== e.r) begin
            errors++;
            $display("FAIL basic_hold: got done=%0d Q=%0d R=%0d required done=0 Q=%0d R=%0d", bus.done, bus.Q, bus.R, e.q, e.r);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int lat, bc;
        @(negedge clk);
        issue(4'd15, 4'd1);
        wait_done(1'b1, 0, lat, bc);
        e = sb.pop_front();
        $display("txn b2b_first A=%0d B=%0d Q=%0d R=%0d divzero=%0d lat=%0d", e.a, e.b, bus.Q, bus.R, bus.divzero, lat);
        checks++;
        if (lat != e.lat || bus.Q !== e.q || bus.R !== e.r) begin
            errors++;
            $display("FAIL b2b_first: got lat=%0d Q=%0d R=%0d required lat=%0d Q=%0d R=%0d", lat, bus.Q, bus.R, e.lat, e.q, e.r);
        end
        issue(4'd3, 4'd7);
        wait_done(1'b0, 0, lat, bc);
        e = sb.pop_front();
        $display("txn b2b_second A=%0d B=%0d Q=%0d R=%0d divzero=%0d lat=%0d", e.a, e.b, bus.Q, bus.R, bus.divzero, lat);
        checks++;
        if (lat != e.lat || bc != e.lat - 1) begin
            errors++;
            $display("FAIL b2b_gap: got lat=%0d busy=%0d required lat=%0d busy=%0d", lat, bc, e.lat, e.lat - 1);
        end
        checks++;
        if (bus.Q !== e.q || bus.R !== e.r) begin
            errors++;
            $display("FAIL b2b_second: got Q=%0d R=%0d required Q=%0d R=%0d", bus.Q, bus.R, e.q, e.r);
        end
    endtask

    task automatic test_ignore_start();
        exp_t e;
        int lat, bc;
        @(negedge clk);
        issue(4'd9, 4'd2);
        wait_done(1'b0, 2, lat, bc);
        e = sb.pop_front();
        $display("txn ignore A=%0d B=%0d Q=%0d R=%0d divzero=%0d lat=%0d", e.a, e.b, bus.Q, bus.R, bus.divzero, lat);
        checks++;
        if (lat != e.lat || bus.Q !== e.q || bus.R !== e.r) begin
            errors++;
            $display("FAIL ignore_start: got lat=%0d Q=%0d R=%0d required lat=%0d Q=%0d R=%0d", lat, bus.Q, bus.R, e.lat, e.q, e.r);
        end
    endtask

    task automatic test_divzero();
        exp_t e;
        int lat, bc;
        @(negedge clk);
        issue(4'd9, 4'd0);
        wait_done(1'b0, 0, lat, bc);
        e = sb.pop_front();
        $display("txn divzero A=%0d B=%0d Q=%0d R=%0d divzero=%0d lat=%0d", e.a, e.b, bus.Q, bus.R, bus.divzero, lat);
        checks++;
        if (lat != e.lat) begin
            errors++;
            $display("FAIL divzero_latency: got %0d required %0d", lat, e.lat);
        end
        checks++;
        if (bus.Q !== e.q || bus.R !== e.r || bus.divzero !== e.dz) begin
            errors++;
            $display("FAIL divzero_result: got Q=%0d R=%0d dz=%0d required Q=%0d R=%0d dz=%0d", bus.Q, bus.R, bus.divzero, e.q, e.r, e.dz);
        end
    endtask

    task automatic test_reset_midrun();
        exp_t e;
        int lat, bc, stray;
        @(negedge clk);
        issue(4'd14, 4'd5);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        #2 n_reset = 1'b0;
        #1;
        void'(sb.pop_front());
        checks++;
        if ({bus.busy, bus.done, bus.divzero} !== 3'b000 || {bus.Q, bus.R} !== 8'h00) begin
            errors++;
            $display("FAIL async_reset: got busy=%0d done=%0d dz=%0d Q=%0d R=%0d required all 0", bus.busy, bus.done, bus.divzero, bus.Q, bus.R);
        end
        @(negedge clk);
        n_reset = 1'b1;
        stray = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) stray++;
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL abort_no_done: got %0d active cycles required 0", stray);
        end
        issue(4'd14, 4'd5);
        wait_done(1'b0, 0, lat, bc);
        e = sb.pop_front();
        $display("txn restart A=%0d B=%0d Q=%0d R=%0d divzero=%0d lat=%0d", e.a, e.b, bus.Q, bus.R, bus.divzero, lat);
        checks++;
        if (lat != e.lat || bus.Q !== e.q || bus.R !== e.r) begin
            errors++;
            $display("FAIL restart: got lat=%0d Q=%0d R=%0d required lat=%0d Q=%0d R=%0d", lat, bus.Q, bus.R, e.lat, e.q, e.r);
        end
    endtask

    task automatic test_sweep();
        exp_t e;
        int lat, bc, qi, ri;
        for (int a = 0; a < 16; a++) begin
            for (int b = 1; b < 16; b++) begin
                @(negedge clk);
                issue(4'(a), 4'(b));
                wait_done(1'b0, 0, lat, bc);
                e = sb.pop_front();
                qi = int'(bus.Q);
                ri = int'(bus.R);
                $display("txn sweep A=%0d B=%0d Q=%0d R=%0d divzero=%0d lat=%0d", a, b, qi, ri, bus.divzero, lat);
                checks++;
                if (bus.Q !== e.q || bus.R !== e.r || bus.divzero !== e.dz || lat != e.lat) begin
                    errors++;
                    $display("FAIL sweep_result A=%0d B=%0d: got Q=%0d R=%0d dz=%0d lat=%0d required Q=%0d R=%0d dz=%0d lat=%0d",
                             a, b, qi, ri, bus.divzero, lat, e.q, e.r, e.dz, e.lat);
                end
                checks++;
                if (qi * b + ri != a || ri >= b) begin
                    errors++;
                    $display("FAIL sweep_identity A=%0d B=%0d: got Q*B+R=%0d R=%0d required %0d with R<B", a, b, qi * b + ri, ri, a);
                end
                @(negedge clk);
                checks++;
                if (bus.done !== 1'b0) begin
                    errors++;
                    $display("FAIL sweep_done_width A=%0d B=%0d: got done=%0d required 0", a, b, bus.done);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_ignore_start();
        test_divzero();
        test_reset_midrun();
        test_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
